// File: rtl/ldmx_dma_link_arb.sv
// ---------------------------------------------------------------------------
// ldmx_dma_link_arb
//
// Packet-level 2:1 arbiter merging two link event AXI-Stream sources into one
// DMA inbound stream. A source is granted for a whole packet (up to tLast).
// When both sources request, the one not served last wins, so sustained
// traffic alternates 0,1,0,1. Each granted packet costs one IDLE cycle of
// arbitration and then passes through with zero added latency.
//
// Optional feature (macro LDMX_DMA_ARB_TIMEOUT_EN): a stall watchdog. If the
// granted source goes idle mid-packet for TIMEOUT_CYCLES cycles, the arbiter
// closes the packet downstream with a synthetic tLast beat flagged EOFE in
// tUser[0], counts it in dropCnt, then discards the rest of the source packet.
// With the macro undefined the arbiter waits forever and dropCnt/tUser are 0.
//
// Parameters
//   TIMEOUT_CYCLES  stall cycles before forced termination (2..65535)
//   DEST_BASE       tDest for source 0; source 1 uses DEST_BASE+1
//
// Ports
//   dmaClk          sole clock, rising edge
//   dmaRst          synchronous active-high reset
//   srcTValid/Last  [1:0] per-source valid / last
//   srcTData        [127:0] 64 bits per source (source 1 in the upper half)
//   srcTKeep        [15:0]  8 bits per source (source 1 in the upper half)
//   srcTReady       [1:0] per-source ready
//   dmaIbT*         merged outbound stream (Valid, Data, Keep, Last, Dest, User)
//   dmaIbTReady     downstream backpressure
//   cntRst          synchronous clear of all counters
//   frameCnt0/1     packets forwarded per source (wrap at 2^32)
//   dropCnt         watchdog terminations (saturating)
// ---------------------------------------------------------------------------
module ldmx_dma_link_arb #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [7:0]  DEST_BASE      = 8'h00
) (
    input  logic         dmaClk,
    input  logic         dmaRst,
    input  logic [1:0]   srcTValid,
    input  logic [1:0]   srcTLast,
    input  logic [127:0] srcTData,
    input  logic [15:0]  srcTKeep,
    output logic [1:0]   srcTReady,
    output logic         dmaIbTValid,
    output logic [63:0]  dmaIbTData,
    output logic [7:0]   dmaIbTKeep,
    output logic         dmaIbTLast,
    output logic [7:0]   dmaIbTDest,
    output logic [63:0]  dmaIbTUser,
    input  logic         dmaIbTReady,
    input  logic         cntRst,
    output logic [31:0]  frameCnt0,
    output logic [31:0]  frameCnt1,
    output logic [15:0]  dropCnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_TERM  = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        g_q, g_d;            // currently granted source
    logic        last_g_q, last_g_d;  // source granted most recently
    logic        grant;

    logic        sel_valid;
    logic        sel_last;
    logic [63:0] sel_data;
    logic [7:0]  sel_keep;
    logic [7:0]  dest;

    logic        out_fire_last;
    logic [31:0] frame_cnt0_q, frame_cnt0_d;
    logic [31:0] frame_cnt1_q, frame_cnt1_d;

    // Granted-source view of the inputs.
    assign sel_valid = srcTValid[g_q];
    assign sel_last  = srcTLast[g_q];
    assign sel_data  = g_q ? srcTData[127:64] : srcTData[63:0];
    assign sel_keep  = g_q ? srcTKeep[15:8]   : srcTKeep[7:0];
    assign dest      = DEST_BASE + {7'd0, g_q};

`ifdef LDMX_DMA_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_CYCLES);

    logic [15:0] stall_q, stall_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        timeout_hit;
    logic        term_fire;

    // The watchdog fires one cycle after the stall count reaches the limit;
    // in that cycle the source is blocked, so a tLast arriving just then is
    // not forwarded and the synthetic terminating beat takes precedence.
    assign timeout_hit = (state_q == ST_PASS) && (stall_q == TIMEOUT_W);
    assign term_fire   = (state_q == ST_TERM) && dmaIbTReady;
    assign dropCnt     = drop_cnt_q;
`else
    logic        timeout_hit;
    logic [15:0] unused_timeout;

    assign timeout_hit    = 1'b0;
    // The timeout length has no function without the watchdog.
    assign unused_timeout = 16'(TIMEOUT_CYCLES);
    assign dropCnt        = 16'h0000;
`endif

    // -----------------------------------------------------------------------
    // Next-state and output decode
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // through the case statement can leave it unassigned (no latches).
        state_d     = state_q;
        g_d         = g_q;
        last_g_d    = last_g_q;
        grant       = g_q;
        srcTReady   = 2'b00;
        dmaIbTValid = 1'b0;
        dmaIbTData  = 64'h0;
        dmaIbTKeep  = 8'h00;
        dmaIbTLast  = 1'b0;
        dmaIbTDest  = dest;
        dmaIbTUser  = 64'h0;
`ifdef LDMX_DMA_ARB_TIMEOUT_EN
        stall_d     = 16'h0000;
`endif

        case (state_q)
            ST_IDLE: begin
                if (|srcTValid) begin
                    // Contention goes to the source not served last.
                    if (&srcTValid) grant = ~last_g_q;
                    else            grant = srcTValid[1];
                    g_d      = grant;
                    last_g_d = grant;
                    state_d  = ST_PASS;
                end
            end

            ST_PASS: begin
                if (timeout_hit) begin
                    state_d = ST_TERM;
                end else begin
                    dmaIbTValid     = sel_valid;
                    dmaIbTData      = sel_data;
                    dmaIbTKeep      = sel_keep;
                    dmaIbTLast      = sel_last;
                    srcTReady[g_q]  = dmaIbTReady;
                    if (sel_valid && dmaIbTReady && sel_last) begin
                        state_d = ST_IDLE;
                    end
`ifdef LDMX_DMA_ARB_TIMEOUT_EN
                    // Count only true source stalls; downstream backpressure
                    // holds the count, any accepted beat clears it.
                    if (sel_valid && dmaIbTReady) stall_d = 16'h0000;
                    else if (!sel_valid)          stall_d = stall_q + 16'd1;
                    else                          stall_d = stall_q;
`endif
                end
            end

`ifdef LDMX_DMA_ARB_TIMEOUT_EN
            ST_TERM: begin
                // Synthetic end-of-frame-with-error beat, held until taken.
                dmaIbTValid = 1'b1;
                dmaIbTKeep  = 8'h01;
                dmaIbTLast  = 1'b1;
                dmaIbTUser  = 64'h1;
                if (dmaIbTReady) state_d = ST_FLUSH;
            end

            ST_FLUSH: begin
                // Drain the remainder of the abandoned source packet.
                srcTReady[g_q] = 1'b1;
                if (sel_valid && sel_last) state_d = ST_IDLE;
            end
`endif

            default: state_d = ST_IDLE;
        endcase

        // Outputs are held quiet while reset is asserted, whatever state the
        // register still shows, so a packet cut by reset emits nothing more.
        if (dmaRst) begin
            srcTReady   = 2'b00;
            dmaIbTValid = 1'b0;
            dmaIbTLast  = 1'b0;
            dmaIbTUser  = 64'h0;
        end
    end

    // -----------------------------------------------------------------------
    // Counters (cntRst beats a simultaneous increment)
    // -----------------------------------------------------------------------
    assign out_fire_last = dmaIbTValid && dmaIbTReady && dmaIbTLast;

    always_comb begin
        frame_cnt0_d = frame_cnt0_q;
        frame_cnt1_d = frame_cnt1_q;
`ifdef LDMX_DMA_ARB_TIMEOUT_EN
        drop_cnt_d   = drop_cnt_q;
`endif
        if (cntRst) begin
            frame_cnt0_d = 32'h0;
            frame_cnt1_d = 32'h0;
`ifdef LDMX_DMA_ARB_TIMEOUT_EN
            drop_cnt_d   = 16'h0;
`endif
        end else begin
            if (out_fire_last && !g_q) frame_cnt0_d = frame_cnt0_q + 32'd1;
            if (out_fire_last &&  g_q) frame_cnt1_d = frame_cnt1_q + 32'd1;
`ifdef LDMX_DMA_ARB_TIMEOUT_EN
            if (term_fire && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
`endif
        end
    end

    assign frameCnt0 = frame_cnt0_q;
    assign frameCnt1 = frame_cnt1_q;

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge dmaClk) begin
        if (dmaRst) begin
            state_q      <= ST_IDLE;
            g_q          <= 1'b0;
            last_g_q     <= 1'b1;   // source 0 wins the first contention
            frame_cnt0_q <= 32'h0;
            frame_cnt1_q <= 32'h0;
`ifdef LDMX_DMA_ARB_TIMEOUT_EN
            stall_q      <= 16'h0;
            drop_cnt_q   <= 16'h0;
`endif
        end else begin
            state_q      <= state_d;
            g_q          <= g_d;
            last_g_q     <= last_g_d;
            frame_cnt0_q <= frame_cnt0_d;
            frame_cnt1_q <= frame_cnt1_d;
`ifdef LDMX_DMA_ARB_TIMEOUT_EN
            stall_q      <= stall_d;
            drop_cnt_q   <= drop_cnt_d;
`endif
        end
    end

endmodule

// File: doc/ldmx_dma_link_arb.md
LDMX_DMA_LINK_ARB -- requirements
Module: ldmx_dma_link_arb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, stall cycles (granted source idle mid-packet) before forced termination, legal 2..65535.
REQ-002 SHALL have parameter DEST_BASE, default 8'h00, tDest emitted for source 0; source 1 emits DEST_BASE+1.
REQ-003 SHALL have port dmaClk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port dmaRst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports srcTValid/srcTLast input 2 (one bit per source), srcTData input 128 (64 per source), srcTKeep input 16 (8 per source): link event streams.
REQ-006 SHALL have port srcTReady  output  2  per-source ready.
REQ-007 SHALL have ports dmaIbTValid out 1, dmaIbTData out 64, dmaIbTKeep out 8, dmaIbTLast out 1, dmaIbTDest out 8, dmaIbTUser out 64: merged DMA inbound stream.
REQ-008 SHALL have port dmaIbTReady  input  1  DMA backpressure.
REQ-009 SHALL have port cntRst  input  1  synchronous clear of all counters.
REQ-010 SHALL have ports frameCnt0/frameCnt1 output 32 (frames forwarded per source) and dropCnt output 16 (timeout terminations).

Function
REQ-011 SHALL implement states IDLE, PASS, TERM, FLUSH; grant register g (1 bit), last-served register lastG.
REQ-012 IDLE: if both srcTValid set, SHALL grant source != lastG; if one set, grant it; none, stay; transition to PASS next cycle, g and lastG updated.
REQ-013 IDLE SHALL drive dmaIbTValid=0, srcTReady=0.
REQ-014 PASS SHALL combinationally route source g: dmaIbTValid=srcTValid[g], data/keep/last from g, srcTReady[g]=dmaIbTReady, srcTReady[!g]=0; zero added latency.
REQ-015 PASS SHALL emit dmaIbTDest=DEST_BASE+g and dmaIbTUser=0.
REQ-016 Beat accepted with tLast (valid&ready&last) in PASS SHALL return to IDLE next cycle; grant held for whole packet, never switched mid-packet.
REQ-017 Packet arbitration SHALL be work-conserving: back-to-back requests from both sources alternate strictly 0,1,0,1.
REQ-018 frameCnt[g] SHALL increment (wrap at 2^32) on each output tLast handshake, including TERM beat.
REQ-019 cntRst SHALL take priority over increment in the same cycle; counters read 0 next cycle.
REQ-020 Non-granted source SHALL hold data untouched (no beat consumed) until granted.

Reset
REQ-021 dmaRst SHALL force state IDLE, g=0, lastG=1 (source 0 wins first contention), stall counter 0, all counters 0.
REQ-022 During and one cycle after dmaRst, outputs SHALL be dmaIbTValid=0, srcTReady=0, dmaIbTLast=0, dmaIbTUser=0.
REQ-023 Reset mid-packet SHALL abandon the packet without emitting a terminating beat; downstream handles the truncation.

Configuration
REQ-024 Macro LDMX_DMA_ARB_TIMEOUT_EN SHALL, when defined, enable the stall watchdog (REQ-025..REQ-028).
REQ-025 With macro: in PASS, stall counter SHALL increment each cycle srcTValid[g]=0, clear on any accepted beat and on entry to PASS.
REQ-026 With macro: counter reaching TIMEOUT_CYCLES SHALL move PASS->TERM; TERM drives dmaIbTValid=1, tLast=1, tData=0, tKeep=8'h01, tUser[0]=1 (EOFE), tDest=DEST_BASE+g, srcTReady=0, held until dmaIbTReady.
REQ-027 With macro: TERM handshake SHALL increment dropCnt (saturate at 16'hFFFF) and go to FLUSH; FLUSH sets srcTReady[g]=1, discards beats, returns to IDLE after discarded tLast; if srcTValid[g]&srcTLast[g] same cycle as timeout, timeout wins.
REQ-028 Without macro: no TERM/FLUSH, PASS waits indefinitely, dropCnt constant 0, dmaIbTUser constant 0.

Verification
REQ-029 Reset, then src0 and src1 each 4-beat packet same cycle -> src0 packet (tDest=0x00) fully out, then src1 (tDest=0x01); frameCnt0=1, frameCnt1=1.
REQ-030 Both sources continuously supply 3 packets each -> output order 0,1,0,1,0,1, no interleaved beats, one idle cycle between packets.
REQ-031 dmaIbTReady toggled 1/0 every cycle during 8-beat src1 packet -> all 8 beats delivered in order, srcTReady[0]=0 throughout.
REQ-032 Macro on, TIMEOUT_CYCLES=16: src0 sends 2 beats then stops 16 cycles -> TERM beat tLast=1, tUser[0]=1, keep=0x01; dropCnt=1; later src0 beats until tLast discarded, next packet forwarded normally.
REQ-033 cntRst asserted same cycle as tLast handshake with frameCnt0=5 -> frameCnt0=0 next cycle.
REQ-034 dmaRst asserted at beat 3 of 6-beat packet -> next cycle all valids/readies 0, counters 0; after release src1-only request granted first-cycle IDLE->PASS.
